fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO. Successor to the fixed 256x8 synchronous FIFO used in the APB I2C slave path.
- Generalises data width and depth, and adds:
  - an exact fill level;
  - programmable almost-full and almost-empty thresholds;
  - sticky overflow and underflow error flags;
  - a synchronous flush;
  - an optional first-word-fall-through (FWFT) read mode.
- Serves as the shared buffering primitive for the peripheral RX/TX data paths.

Parameters:
- DATA_WIDTH, 8: width of each stored word in bits.
- ADDR_WIDTH, 8: log2 of the depth. DEPTH = 2**ADDR_WIDTH. Legal range is 2 to 12.
- FWFT, 0: read mode. 0 = standard (data follows an accepted pop). 1 = first-word-fall-through (head word is presented while not empty).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  synchronous clear of FIFO contents and error flags.
- push_i  in  1  write request.
- wr_data_i  in  DATA_WIDTH  write data.
- pop_i  in  1  read request.
- rd_data_o  out  DATA_WIDTH  read data.
- afull_thresh_i  in  ADDR_WIDTH+1  almost-full threshold (level).
- aempty_thresh_i  in  ADDR_WIDTH+1  almost-empty threshold (level).
- full_o  out  1  level_o == DEPTH.
- empty_o  out  1  no word available to read.
- almost_full_o  out  1  level_o >= afull_thresh_i.
- almost_empty_o  out  1  level_o <= aempty_thresh_i.
- level_o  out  ADDR_WIDTH+1  number of stored words, 0..DEPTH.
- overflow_o  out  1  sticky; a push was rejected.
- underflow_o  out  1  sticky; a pop was rejected.

Behaviour:
- Reset (rst_i=1 at a clock edge) values:
  - Pointers = 0, level_o = 0, rd_data_o = 0.
  - empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = 0.
  - overflow_o = 0, underflow_o = 0.
  - Reset overrides flush, push and pop in the same cycle. Reset mid-stream discards all data.
- Acceptance:
  - A push is accepted iff push_i & !full_o.
  - A pop is accepted iff pop_i & !empty_o.
  - Both are evaluated on the current registered flags; there is no same-cycle pass-through.
- Simultaneous push and pop:
  - Neither full nor empty: both accepted, level unchanged.
  - Full: pop accepted, push rejected, overflow_o set.
  - Empty: push accepted, pop rejected, underflow_o set.
- Error flags:
  - Rejected push or pop still sets the sticky flag.
  - Sticky flags clear only on rst_i or flush_i.
- Pointers:
  - Write and read pointers are ADDR_WIDTH wide and wrap modulo DEPTH.
  - level_o is a separate counter: +1 on an accepted push only, -1 on an accepted pop only.
- Flag timing:
  - All flags are registered and computed from the next level value, so they change on the same edge as level_o.
  - The threshold compare uses the live threshold inputs.
- Flush:
  - flush_i=1 clears pointers, level, rd_data_o and both sticky flags in one cycle.
  - push and pop in the flush cycle are ignored and raise no errors.
  - RAM contents are not cleared.
- FWFT=0:
  - rd_data_o updates on the edge after an accepted pop (1-cycle latency) and holds until the next accepted pop.
  - empty_o deasserts on the edge after the first accepted push into an empty FIFO.
- FWFT=1:
  - A head-of-queue output register is prefetched from the RAM.
  - empty_o=0 means rd_data_o holds the head word. Push into an empty FIFO gives empty_o=0 two edges later.
  - An accepted pop presents the next word on the following edge if one is stored; otherwise empty_o returns to 1.
  - level_o includes the word held in the output register.
  - full_o asserts at level_o == DEPTH; the RAM plus output register hold DEPTH words in total.
- Write to RAM only on an accepted push; a rejected push leaves memory unchanged.

Decomposition:
- Shared package fifo_pkg holds:
  - the FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1 constants;
  - a level-width helper function (ADDR_WIDTH+1).
- One sub-module, ram_sdp_sync: a simple dual-port memory with one write port and one read port, synchronous read, DATA_WIDTH x 2**ADDR_WIDTH, single clock.
- Pointer, level, flag and FWFT prefetch logic stay in fifo_sync_param.

Test Plan:
- All scenarios use DATA_WIDTH=8 and ADDR_WIDTH=4 (DEPTH=16), FWFT=0 unless stated.
- Fill/drain: push 0x00..0x0F on consecutive cycles -> full_o=1 and level_o=16 after the 16th push; then 16 pops -> rd_data_o reads 0x00..0x0F in order, each 1 cycle after its pop; empty_o=1, level_o=0.
- Overflow/underflow: on a full FIFO, push 0xAA -> level_o stays 16, overflow_o=1, RAM unchanged. On an empty FIFO, pop -> underflow_o=1, level_o=0. Then flush_i -> both flags 0.
- Simultaneous events:
  - Level 5, push+pop -> level_o stays 5.
  - Full, push+pop -> level_o=15, overflow_o=1.
  - Empty, push+pop -> level_o=1, underflow_o=1.
- Thresholds and wrap: afull_thresh_i=12, aempty_thresh_i=3. Push 8, pop 8, push 12 (pointers wrap past 15) -> almost_empty_o clears at level 4, almost_full_o asserts at level 12, data order preserved across the wrap.
- FWFT=1: push 0x5A into empty -> empty_o=0 and rd_data_o=0x5A two edges later without a pop. Pop -> empty_o=1 next edge, level_o=0.
- Reset/flush mid-stream: level 9 with push and pop both active when rst_i=1 -> next edge level_o=0, empty_o=1, rd_data_o=0x00, no error flags. Same check with flush_i=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the parametrised synchronous FIFO.
//   FIFO_MODE_STD  : read data follows an accepted pop by one cycle
//   FIFO_MODE_FWFT : head word is presented on rd_data_o while not empty
//   lvl_width()    : width of a fill-level value (0..DEPTH inclusive)
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // A level of 0..2**addr_width needs one bit more than a pointer.
  function automatic int lvl_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/ram_sdp_sync.sv
// ---------------------------------------------------------------------------
// ram_sdp_sync
// Simple dual-port RAM: one write port, one read port, single clock,
// synchronous (registered) read. No reset on storage or read register.
// Ports:
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable; rdata_o loads mem[raddr_i] on the next edge
//   raddr_i  : read address
//   rdata_o  : registered read data, holds while re_i is low
// ---------------------------------------------------------------------------
module ram_sdp_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
    if (re_i) r_rdata <= r_mem[raddr_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
// Parametrised single-clock FIFO with exact fill level, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and optional first-word-fall-through read mode.
// ADDR_WIDTH legal range is 2..12 (DEPTH = 2**ADDR_WIDTH).
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   flush_i                 : clear contents and sticky flags in one cycle
//   push_i / wr_data_i      : write request and data
//   pop_i / rd_data_o       : read request and data
//   afull_thresh_i          : almost_full_o  = level_o >= threshold
//   aempty_thresh_i         : almost_empty_o = level_o <= threshold
//   full_o, empty_o         : status flags (registered)
//   level_o                 : stored words, 0..DEPTH
//   overflow_o, underflow_o : sticky rejected push / rejected pop
// ---------------------------------------------------------------------------
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FWFT       = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic [ADDR_WIDTH:0]   afull_thresh_i,
  input  logic [ADDR_WIDTH:0]   aempty_thresh_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int LW = lvl_width(ADDR_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
  logic [LW-1:0]         r_level;
  logic                  r_full, r_empty, r_afull, r_aempty;
  logic                  r_ovf, r_udf;
  // Masks the RAM read register to zero after reset/flush until the
  // next read loads it, so rd_data_o reads 0 without resetting the RAM.
  logic                  r_rd_clr;

  logic                  w_push_acc, w_pop_acc, w_rd_en, w_empty_nxt;
  logic [LW-1:0]         w_level_nxt, w_ram_cnt;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  assign w_push_acc = push_i & ~r_full  & ~flush_i & ~rst_i;
  assign w_pop_acc  = pop_i  & ~r_empty & ~flush_i & ~rst_i;

  // In FWFT mode the RAM read register is the head register; words still
  // sitting in RAM are the level minus the one presented at the output.
  assign w_ram_cnt = r_level - (r_empty ? '0 : LVL_ONE);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push_acc && !w_pop_acc)      w_level_nxt = r_level + LVL_ONE;
    else if (!w_push_acc && w_pop_acc) w_level_nxt = r_level - LVL_ONE;
  end

  always_comb begin
    w_rd_en     = 1'b0;
    w_empty_nxt = 1'b1;
    if (FWFT == FIFO_MODE_FWFT) begin
      // Prefetch when the head slot is free or being vacated by this pop.
      w_rd_en     = (w_ram_cnt != '0) && (r_empty || w_pop_acc)
                    && !flush_i && !rst_i;
      w_empty_nxt = !(w_rd_en || (!r_empty && !w_pop_acc));
    end else begin
      w_rd_en     = w_pop_acc;
      w_empty_nxt = (w_level_nxt == '0);
    end
  end

  ram_sdp_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_push_acc),
    .waddr_i (r_wptr),
    .wdata_i (wr_data_i),
    .re_i    (w_rd_en),
    .raddr_i (r_rptr),
    .rdata_o (w_ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_rd_clr <= 1'b1;
    end else if (flush_i) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= (afull_thresh_i == '0);
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_rd_clr <= 1'b1;
    end else begin
      if (w_push_acc) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd_en) begin
        r_rptr   <= r_rptr + PTR_ONE;
        r_rd_clr <= 1'b0;
      end
      r_level  <= w_level_nxt;
      r_full   <= (w_level_nxt == DEPTH_LVL);
      r_empty  <= w_empty_nxt;
      r_afull  <= (w_level_nxt >= afull_thresh_i);
      r_aempty <= (w_level_nxt <= aempty_thresh_i);
      if (push_i && r_full)  r_ovf <= 1'b1;
      if (pop_i  && r_empty) r_udf <= 1'b1;
    end
  end

  assign rd_data_o      = r_rd_clr ? '0 : w_ram_rdata;
  assign full_o         = r_full;
  assign empty_o        = r_empty;
  assign almost_full_o  = r_afull;
  assign almost_empty_o = r_aempty;
  assign level_o        = r_level;
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_udf;

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst, flush, push, pop;
  logic [7:0] wdata;
  logic [4:0] afull_th, aempty_th;
  logic [7:0] rd;
  logic       full, empty, afull, aempty, ovf, udf;
  logic [4:0] level;

  logic       b_flush, b_push, b_pop;
  logic [7:0] b_wdata, b_rd;
  logic       b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
  logic [4:0] b_level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut_std (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push),
    .wr_data_i(wdata), .pop_i(pop), .rd_data_o(rd),
    .afull_thresh_i(afull_th), .aempty_thresh_i(aempty_th),
    .full_o(full), .empty_o(empty), .almost_full_o(afull),
    .almost_empty_o(aempty), .level_o(level),
    .overflow_o(ovf), .underflow_o(udf)
  );

  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut_fwft (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .push_i(b_push),
    .wr_data_i(b_wdata), .pop_i(b_pop), .rd_data_o(b_rd),
    .afull_thresh_i(afull_th), .aempty_thresh_i(aempty_th),
    .full_o(b_full), .empty_o(b_empty), .almost_full_o(b_afull),
    .almost_empty_o(b_aempty), .level_o(b_level),
    .overflow_o(b_ovf), .underflow_o(b_udf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_push(input logic [7:0] d);
    push = 1'b1; wdata = d; tick(); push = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1; tick(); pop = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; wdata = '0;
    b_flush = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_wdata = '0;
    afull_th = 5'd12; aempty_th = 5'd3;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_aempty", aempty, 1);
    chk("rst_afull", afull, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    chk("rst_rd", rd, 0);

    // fill 0x00..0x0F with threshold tracking
    for (int i = 0; i < 16; i++) begin
      do_push(8'(i));
      chk("fill_level", level, i + 1);
      chk("fill_empty", empty, 0);
      chk("fill_full", full, (i + 1) == 16);
      chk("fill_aempty", aempty, (i + 1) <= 3);
      chk("fill_afull", afull, (i + 1) >= 12);
    end

    // overflow on full
    do_push(8'hAA);
    chk("ovf_level", level, 16);
    chk("ovf_flag", ovf, 1);
    chk("ovf_full", full, 1);

    // drain: data one cycle after each pop, 0xAA never appears
    for (int i = 0; i < 16; i++) begin
      do_pop();
      chk("drain_data", rd, i);
      chk("drain_level", level, 15 - i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_full", full, 0);
    tick();
    chk("drain_hold", rd, 8'h0F);

    // underflow on empty
    do_pop();
    chk("udf_flag", udf, 1);
    chk("udf_level", level, 0);
    chk("udf_rd_hold", rd, 8'h0F);
    chk("udf_ovf_sticky", ovf, 1);

    do_flush();
    chk("flush_ovf", ovf, 0);
    chk("flush_udf", udf, 0);
    chk("flush_rd", rd, 0);
    chk("flush_empty", empty, 1);

    // simultaneous push+pop at level 5
    for (int i = 0; i < 5; i++) do_push(8'(8'h10 + i));
    push = 1'b1; pop = 1'b1; wdata = 8'h15; tick(); push = 1'b0; pop = 1'b0;
    chk("sim5_level", level, 5);
    chk("sim5_rd", rd, 8'h10);
    for (int i = 0; i < 11; i++) do_push(8'(8'h16 + i));
    chk("simfull_pre", full, 1);
    push = 1'b1; pop = 1'b1; wdata = 8'hEE; tick(); push = 1'b0; pop = 1'b0;
    chk("simfull_level", level, 15);
    chk("simfull_ovf", ovf, 1);
    chk("simfull_rd", rd, 8'h11);
    do_flush();
    push = 1'b1; pop = 1'b1; wdata = 8'h77; tick(); push = 1'b0; pop = 1'b0;
    chk("simempty_level", level, 1);
    chk("simempty_udf", udf, 1);
    chk("simempty_empty", empty, 0);
    do_pop();
    chk("simempty_data", rd, 8'h77);
    do_flush();

    // thresholds and pointer wrap
    for (int i = 0; i < 8; i++) do_push(8'(8'h20 + i));
    for (int i = 0; i < 8; i++) begin
      do_pop();
      chk("wrap_pre_data", rd, 8'h20 + i);
    end
    for (int i = 0; i < 12; i++) begin
      do_push(8'(8'h40 + i));
      chk("wrap_aempty", aempty, (i + 1) <= 3);
      chk("wrap_afull", afull, (i + 1) >= 12);
    end
    chk("wrap_level", level, 12);
    for (int i = 0; i < 12; i++) begin
      do_pop();
      chk("wrap_data", rd, 8'h40 + i);
    end
    chk("wrap_empty", empty, 1);

    // reset mid-stream with push and pop active
    for (int i = 0; i < 10; i++) do_push(8'(8'h60 + i));
    do_pop();
    chk("mid_pre_level", level, 9);
    chk("mid_pre_rd", rd, 8'h60);
    rst = 1'b1; push = 1'b1; pop = 1'b1; wdata = 8'h99; tick();
    rst = 1'b0; push = 1'b0; pop = 1'b0;
    chk("midrst_level", level, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_rd", rd, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_udf", udf, 0);

    // flush mid-stream with push and pop active
    for (int i = 0; i < 10; i++) do_push(8'(8'h80 + i));
    do_pop();
    chk("mid2_pre_rd", rd, 8'h80);
    flush = 1'b1; push = 1'b1; pop = 1'b1; wdata = 8'h99; tick();
    flush = 1'b0; push = 1'b0; pop = 1'b0;
    chk("midfl_level", level, 0);
    chk("midfl_empty", empty, 1);
    chk("midfl_rd", rd, 0);
    chk("midfl_ovf", ovf, 0);
    chk("midfl_udf", udf, 0);

    // FWFT instance
    chk("fw_rst_empty", b_empty, 1);
    chk("fw_rst_rd", b_rd, 0);
    b_push = 1'b1; b_wdata = 8'h5A; tick(); b_push = 1'b0;
    chk("fw_e1_empty", b_empty, 1);
    chk("fw_e1_level", b_level, 1);
    tick();
    chk("fw_e2_empty", b_empty, 0);
    chk("fw_e2_rd", b_rd, 8'h5A);
    b_pop = 1'b1; tick(); b_pop = 1'b0;
    chk("fw_pop_empty", b_empty, 1);
    chk("fw_pop_level", b_level, 0);
    chk("fw_pop_udf", b_udf, 0);
    b_push = 1'b1; b_wdata = 8'h11; tick();
    b_wdata = 8'h22; tick(); b_push = 1'b0;
    chk("fw_two_empty", b_empty, 0);
    chk("fw_two_rd", b_rd, 8'h11);
    b_pop = 1'b1; tick(); b_pop = 1'b0;
    chk("fw_next_rd", b_rd, 8'h22);
    chk("fw_next_empty", b_empty, 0);
    chk("fw_next_level", b_level, 1);
    b_pop = 1'b1; tick(); b_pop = 1'b0;
    chk("fw_last_empty", b_empty, 1);
    chk("fw_last_level", b_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
